// File: rtl/rv_div_pkg.sv
// Shared types and encodings for the iterative RV M-extension divider.
// Macros: RV64 selects XLEN=64 and enables the W-type encodings.
package rv_div_pkg;

`ifdef RV64
    localparam int XLEN = 64;
`else
    localparam int XLEN = 32;
`endif

    localparam int DIV_TYPE_BUS = 3;
    localparam int DIV_CNT_BUS  = 6;

    localparam logic [DIV_TYPE_BUS-1:0] DIV_DIV_TYPE   = 3'd0;
    localparam logic [DIV_TYPE_BUS-1:0] DIV_DIVU_TYPE  = 3'd1;
    localparam logic [DIV_TYPE_BUS-1:0] DIV_REM_TYPE   = 3'd2;
    localparam logic [DIV_TYPE_BUS-1:0] DIV_REMU_TYPE  = 3'd3;
    localparam logic [DIV_TYPE_BUS-1:0] DIV_DIVW_TYPE  = 3'd4;
    localparam logic [DIV_TYPE_BUS-1:0] DIV_DIVUW_TYPE = 3'd5;
    localparam logic [DIV_TYPE_BUS-1:0] DIV_REMW_TYPE  = 3'd6;
    localparam logic [DIV_TYPE_BUS-1:0] DIV_REMUW_TYPE = 3'd7;

    typedef enum logic [1:0] {
        DIV_ST_IDLE  = 2'd0,
        DIV_ST_CALC  = 2'd1,
        DIV_ST_FIXUP = 2'd2,
        DIV_ST_DONE  = 2'd3
    } div_state_e;

    typedef struct packed {
        logic is_signed;
        logic is_rem;
        logic is_w;
    } div_op_t;

    // Anything not recognised (including W codes on RV32) behaves as DIVU.
    function automatic div_op_t decode_type(input logic [DIV_TYPE_BUS-1:0] t);
        div_op_t o;
        o = '0;
        case (t)
            DIV_DIV_TYPE:  o.is_signed = 1'b1;
            DIV_REM_TYPE:  begin o.is_signed = 1'b1; o.is_rem = 1'b1; end
            DIV_REMU_TYPE: o.is_rem = 1'b1;
`ifdef RV64
            DIV_DIVW_TYPE:  begin o.is_signed = 1'b1; o.is_w = 1'b1; end
            DIV_DIVUW_TYPE: o.is_w = 1'b1;
            DIV_REMW_TYPE:  begin o.is_signed = 1'b1; o.is_rem = 1'b1; o.is_w = 1'b1; end
            DIV_REMUW_TYPE: begin o.is_rem = 1'b1; o.is_w = 1'b1; end
`endif
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/rv_div_step.sv
// Purpose: one combinational restoring-division step on magnitudes.
// Latency: 0 cycles. Backpressure: none, pure combinational.
module rv_div_step
    import rv_div_pkg::*;
(
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_nxt,
    output logic [XLEN-1:0] quo_nxt
);
    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    // rem < divisor always holds, so bit XLEN of trial is set exactly on borrow.
    always_comb begin
        shifted = {rem, quo[XLEN-1]};
        trial   = shifted - {1'b0, divisor};
        if (!trial[XLEN]) begin
            rem_nxt = trial[XLEN-1:0];
            quo_nxt = {quo[XLEN-2:0], 1'b1};
        end else begin
            rem_nxt = shifted[XLEN-1:0];
            quo_nxt = {quo[XLEN-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/rv_div.sv
// Purpose: iterative radix-2 divider (DIV/DIVU/REM/REMU, W types under RV64; early-out under DIV_EARLY_OUT_EN).
// Latency: N+2 cycles from accept to res_valid, 1 cycle for divide-by-zero/overflow (and early-out).
// Backpressure: div_ready only in IDLE; result held in DONE until res_ready; flush aborts anything.
module rv_div
    import rv_div_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    div_valid,
    output logic                    div_ready,
    input  logic [DIV_TYPE_BUS-1:0] div_type,
    input  logic [XLEN-1:0]         rs1_data,
    input  logic [XLEN-1:0]         rs2_data,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [XLEN-1:0]         res_data
);
    div_state_e             state;
    logic [DIV_CNT_BUS-1:0] cnt;
    logic [XLEN-1:0]        rem;
    logic [XLEN-1:0]        quo;
    logic [XLEN-1:0]        divisor;
    logic                   q_neg;
    logic                   r_neg;
    logic                   is_rem;
`ifdef RV64
    logic                   is_w;
`endif

    div_op_t                op;
    logic [XLEN-1:0]        a_ext;
    logic [XLEN-1:0]        b_ext;
    logic [XLEN-1:0]        a_abs;
    logic [XLEN-1:0]        b_abs;
    logic [XLEN-1:0]        min_neg;
    logic [XLEN-1:0]        special_res;
    logic [XLEN-1:0]        special_out;
    logic [XLEN-1:0]        quo_init;
    logic [DIV_CNT_BUS-1:0] cnt_init;
    logic                   a_neg;
    logic                   b_neg;
    logic                   div_zero;
    logic                   ovf;
    logic                   early;

    logic [XLEN-1:0]        rem_nxt;
    logic [XLEN-1:0]        quo_nxt;
    logic [XLEN-1:0]        q_fix;
    logic [XLEN-1:0]        r_fix;
    logic [XLEN-1:0]        fix_sel;
    logic [XLEN-1:0]        fix_res;

    rv_div_step u_step (
        .rem     (rem),
        .quo     (quo),
        .divisor (divisor),
        .rem_nxt (rem_nxt),
        .quo_nxt (quo_nxt)
    );

    // Operand preparation for the accept cycle.
    always_comb begin
        op       = decode_type(div_type);
        a_ext    = rs1_data;
        b_ext    = rs2_data;
        min_neg  = {1'b1, {(XLEN-1){1'b0}}};
`ifdef RV64
        if (op.is_w) begin
            a_ext   = op.is_signed ? {{32{rs1_data[31]}}, rs1_data[31:0]} : {32'b0, rs1_data[31:0]};
            b_ext   = op.is_signed ? {{32{rs2_data[31]}}, rs2_data[31:0]} : {32'b0, rs2_data[31:0]};
            min_neg = {{33{1'b1}}, 31'b0};
        end
`endif
        a_neg    = op.is_signed & a_ext[XLEN-1];
        b_neg    = op.is_signed & b_ext[XLEN-1];
        a_abs    = a_neg ? -a_ext : a_ext;
        b_abs    = b_neg ? -b_ext : b_ext;
        div_zero = (b_ext == '0);
        ovf      = op.is_signed & (a_ext == min_neg) & (b_ext == '1);
`ifdef DIV_EARLY_OUT_EN
        early    = !div_zero && (a_abs < b_abs);
`else
        early    = 1'b0;
`endif
        if (div_zero)
            special_res = op.is_rem ? a_ext : '1;
        else if (ovf)
            special_res = op.is_rem ? '0 : a_ext;
        else
            special_res = op.is_rem ? a_ext : '0;
        special_out = special_res;
        quo_init    = a_abs;
        cnt_init    = op.is_w ? DIV_CNT_BUS'(31) : DIV_CNT_BUS'(XLEN-1);
`ifdef RV64
        // W results are always the sign-extended low word, even for unsigned types.
        if (op.is_w) begin
            special_out = {{32{special_res[31]}}, special_res[31:0]};
            quo_init    = {a_abs[31:0], 32'b0};
        end
`endif
    end

    always_comb begin
        q_fix   = q_neg ? -quo : quo;
        r_fix   = r_neg ? -rem : rem;
        fix_sel = is_rem ? r_fix : q_fix;
        fix_res = fix_sel;
`ifdef RV64
        if (is_w) fix_res = {{32{fix_sel[31]}}, fix_sel[31:0]};
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= DIV_ST_IDLE;
            cnt       <= '0;
            rem       <= '0;
            quo       <= '0;
            divisor   <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            is_rem    <= 1'b0;
`ifdef RV64
            is_w      <= 1'b0;
`endif
            div_ready <= 1'b1;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else if (flush) begin
            state     <= DIV_ST_IDLE;
            div_ready <= 1'b1;
            res_valid <= 1'b0;
        end else begin
            case (state)
                DIV_ST_IDLE: begin
                    if (div_valid) begin
                        div_ready <= 1'b0;
                        q_neg     <= op.is_signed & (a_neg ^ b_neg);
                        r_neg     <= a_neg;
                        is_rem    <= op.is_rem;
`ifdef RV64
                        is_w      <= op.is_w;
`endif
                        if (div_zero || ovf || early) begin
                            res_data  <= special_out;
                            res_valid <= 1'b1;
                            state     <= DIV_ST_DONE;
                        end else begin
                            rem     <= '0;
                            quo     <= quo_init;
                            divisor <= b_abs;
                            cnt     <= cnt_init;
                            state   <= DIV_ST_CALC;
                        end
                    end
                end
                DIV_ST_CALC: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt - DIV_CNT_BUS'(1);
                    if (cnt == '0) state <= DIV_ST_FIXUP;
                end
                DIV_ST_FIXUP: begin
                    res_data  <= fix_res;
                    res_valid <= 1'b1;
                    state     <= DIV_ST_DONE;
                end
                DIV_ST_DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        div_ready <= 1'b1;
                        state     <= DIV_ST_IDLE;
                    end
                end
                default: state <= DIV_ST_IDLE;
            endcase
        end
    end
endmodule
